// File: rtl/etherneco_pkg.sv
// Shared types and constants for the etherneco packet transmit path.
package etherneco_pkg;

    // Arbiter sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SEND,
        ST_WAIT_END,
        ST_FLUSH
    } t_state;

    // Frame header fields.
    typedef logic [15:0] t_length;
    typedef logic [7:0]  t_type;
    typedef logic [7:0]  t_node;

    // Framing constants shared with the transmitter.
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         PREAMBLE_LEN  = 7;

    // Width of a port index; a single port still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/etherneco_rr_select.sv
// Combinational round-robin priority select: first requester at or above
// the pointer, wrapping around to port 0.
module etherneco_rr_select
    import etherneco_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_any
);

    int w_pos;

    // Scan NUM_PORTS positions starting at the pointer; first hit wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NUM_PORTS) begin
                w_pos = w_pos - NUM_PORTS;
            end
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_idx          = IDX_W'(w_pos);
                o_grant[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/etherneco_packet_tx_arbiter.sv
// Round-robin scheduler sharing one etherneco packet transmitter among
// NUM_PORTS requesters, with payload-stall timeout and flush.
module etherneco_packet_tx_arbiter
    import etherneco_pkg::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TIMEOUT_WIDTH-1:0] param_timeout,
    input  logic [NUM_PORTS-1:0]     s_req,
    input  logic [NUM_PORTS*16-1:0]  s_length,
    input  logic [NUM_PORTS*8-1:0]   s_type,
    input  logic [NUM_PORTS*8-1:0]   s_node,
    output logic [NUM_PORTS-1:0]     s_grant,
    output logic [NUM_PORTS-1:0]     s_done,
    output logic [NUM_PORTS-1:0]     s_abort,
    input  logic [NUM_PORTS-1:0]     s_payload_last,
    input  logic [NUM_PORTS*8-1:0]   s_payload_data,
    input  logic [NUM_PORTS-1:0]     s_payload_valid,
    output logic [NUM_PORTS-1:0]     s_payload_ready,
    output logic                     m_start,
    output logic                     m_cancel,
    output logic [15:0]              m_param_length,
    output logic [7:0]               m_param_type,
    output logic [7:0]               m_param_node,
    input  logic                     m_tx_start,
    output logic                     m_payload_last,
    output logic [7:0]               m_payload_data,
    output logic                     m_payload_valid,
    input  logic                     m_payload_ready,
    input  logic                     m_tx_last,
    input  logic                     m_tx_valid,
    input  logic                     m_tx_ready
);

    localparam int IDX_W = idx_width(NUM_PORTS);

    t_state                   r_state;
    t_state                   w_state_next;
    logic [NUM_PORTS-1:0]     r_grant;
    logic [IDX_W-1:0]         r_grant_idx;
    logic [IDX_W-1:0]         r_rr_ptr;
    logic [TIMEOUT_WIDTH-1:0] r_timer;
    t_length                  r_length;
    t_type                    r_type;
    t_node                    r_node;

    t_length                  w_length [NUM_PORTS];
    t_type                    w_type   [NUM_PORTS];
    t_node                    w_node   [NUM_PORTS];
    logic [7:0]               w_data   [NUM_PORTS];

    logic [NUM_PORTS-1:0]     w_sel_grant;
    logic [IDX_W-1:0]         w_sel_idx;
    logic                     w_sel_any;
    logic                     w_g_valid;
    logic                     w_g_last;
    logic                     w_send_hs;
    logic                     w_timeout;
    logic                     w_tx_end;
    logic                     w_flush_last;
    logic [IDX_W-1:0]         w_next_ptr;

    // Split the flat per-port buses into indexable arrays.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign w_length[gi] = s_length[gi*16 +: 16];
            assign w_type[gi]   = s_type[gi*8 +: 8];
            assign w_node[gi]   = s_node[gi*8 +: 8];
            assign w_data[gi]   = s_payload_data[gi*8 +: 8];
        end
    endgenerate

    etherneco_rr_select #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_select (
        .i_req   (s_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_sel_grant),
        .o_idx   (w_sel_idx),
        .o_any   (w_sel_any)
    );

    assign w_g_valid    = s_payload_valid[r_grant_idx];
    assign w_g_last     = s_payload_last[r_grant_idx];
    assign w_send_hs    = w_g_valid && m_payload_ready;
    // Fires on the cycle the counter would reach param_timeout stalls.
    assign w_timeout    = (param_timeout != '0) &&
                          (r_timer == param_timeout - TIMEOUT_WIDTH'(1));
    assign w_tx_end     = m_tx_valid && m_tx_ready && m_tx_last;
    assign w_flush_last = w_g_valid && w_g_last;
    assign w_next_ptr   = (r_grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0
                                                                 : r_grant_idx + IDX_W'(1);

    assign s_grant        = r_grant;
    assign m_param_length = r_length;
    assign m_param_type   = r_type;
    assign m_param_node   = r_node;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a final-byte handshake takes priority over timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_sel_any)  w_state_next = ST_START;
            ST_START:    if (m_tx_start) w_state_next = ST_SEND;
            ST_SEND: begin
                if (w_send_hs && w_g_last)    w_state_next = ST_WAIT_END;
                else if (!w_send_hs && w_timeout) w_state_next = ST_FLUSH;
            end
            ST_WAIT_END: if (w_tx_end)     w_state_next = ST_IDLE;
            ST_FLUSH:    if (w_flush_last) w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // Outputs: start strobe, payload routing, completion/abort pulses.
    always_comb begin
        m_start         = 1'b0;
        m_cancel        = 1'b0;
        m_payload_valid = 1'b0;
        m_payload_last  = 1'b0;
        m_payload_data  = '0;
        s_payload_ready = '0;
        s_done          = '0;
        s_abort         = '0;
        case (r_state)
            ST_START: m_start = 1'b1;
            ST_SEND: begin
                m_payload_valid              = w_g_valid;
                m_payload_last               = w_g_last;
                m_payload_data               = w_data[r_grant_idx];
                s_payload_ready[r_grant_idx] = m_payload_ready;
                if (!w_send_hs && w_timeout) begin
                    m_cancel             = 1'b1;
                    s_abort[r_grant_idx] = 1'b1;
                end
            end
            ST_WAIT_END: if (w_tx_end) s_done[r_grant_idx] = 1'b1;
            ST_FLUSH:    s_payload_ready[r_grant_idx] = 1'b1;
            default: ;
        endcase
    end

    // Grant, header latch, round-robin pointer and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_timer     <= '0;
            r_length    <= '0;
            r_type      <= '0;
            r_node      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_any) begin
                        r_grant     <= w_sel_grant;
                        r_grant_idx <= w_sel_idx;
                        r_length    <= w_length[w_sel_idx];
                        r_type      <= w_type[w_sel_idx];
                        r_node      <= w_node[w_sel_idx];
                    end
                end
                ST_START: r_timer <= '0;
                ST_SEND: begin
                    if (w_send_hs) begin
                        r_timer <= '0;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + TIMEOUT_WIDTH'(1);
                    end
                end
                ST_WAIT_END: begin
                    if (w_tx_end) begin
                        r_grant  <= '0;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                ST_FLUSH: begin
                    if (w_flush_last) begin
                        r_grant  <= '0;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/etherneco_packet_tx_arbiter.md
Name: etherneco_packet_tx_arbiter

Overview:
Round-robin scheduler that shares one etherneco packet transmitter among NUM_PORTS requesters.
- Grants one requester at a time and latches its length/type/node header parameters.
- Issues start to the transmitter and routes the granted payload stream into it.
- Releases the grant when the transmitter emits the frame's last byte.
- Supervises payload stalls with a timeout that cancels the frame and flushes the requester's remaining payload.

Parameters:
NUM_PORTS, 2, number of requesters (1..16)
TIMEOUT_WIDTH, 16, width of the stall-timeout counter and of param_timeout

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
param_timeout  input  TIMEOUT_WIDTH  max payload-stall cycles in SEND; 0 disables the timeout
s_req  input  NUM_PORTS  per-port transmit request, level, held until s_grant
s_length  input  NUM_PORTS*16  per-port payload length minus 1
s_type  input  NUM_PORTS*8  per-port packet type
s_node  input  NUM_PORTS*8  per-port node id
s_grant  output  NUM_PORTS  one-hot, owner of the transmitter
s_done  output  NUM_PORTS  1-cycle pulse, frame completed
s_abort  output  NUM_PORTS  1-cycle pulse, frame cancelled by timeout
s_payload_last  input  NUM_PORTS  per-port payload last
s_payload_data  input  NUM_PORTS*8  per-port payload byte
s_payload_valid  input  NUM_PORTS  per-port payload valid
s_payload_ready  output  NUM_PORTS  per-port payload ready
m_start  output  1  transmitter start request
m_cancel  output  1  transmitter cancel, 1-cycle pulse
m_param_length  output  16  latched length
m_param_type  output  8  latched type
m_param_node  output  8  latched node
m_tx_start  input  1  transmitter accepted start (same cycle as m_start)
m_payload_last  output  1  routed payload last
m_payload_data  output  8  routed payload byte
m_payload_valid  output  1  routed payload valid
m_payload_ready  input  1  transmitter payload ready
m_tx_last  input  1  transmitter output stream, monitored only
m_tx_valid  input  1  transmitter output stream, monitored only
m_tx_ready  input  1  transmitter output stream, monitored only

Behaviour:
- Reset values: state IDLE, all outputs 0, rr pointer 0, m_param_* = 0.
- States: IDLE, START, SEND, WAIT_END, FLUSH.
- IDLE:
  - Any s_req set: winner is the first set bit scanning from rr_ptr upward, wrapping modulo NUM_PORTS.
  - Same edge: latch that port's s_length/s_type/s_node into m_param_*, set s_grant one-hot, go START.
  - No s_req: stay.
- START:
  - m_start=1.
  - m_tx_start=1 in a cycle: go SEND next edge; clear timeout counter.
  - m_param_* stable from START until IDLE.
- SEND:
  - Payload path is combinational for the granted port g: m_payload_* = s_payload_*[g], s_payload_ready[g] = m_payload_ready.
  - All other ports' s_payload_ready = 0. In every other state, m_payload_valid = 0.
  - Handshake with last: go WAIT_END.
  - Timeout counter: clears on any handshake; otherwise increments, saturating.
  - param_timeout!=0 and counter==param_timeout-1 with no handshake: m_cancel=1 that cycle, s_abort[g]=1, go FLUSH.
  - Handshake-with-last wins over timeout in the same cycle.
- WAIT_END:
  - m_tx_valid && m_tx_ready && m_tx_last: s_done[g]=1, s_grant cleared, rr_ptr=(g+1) mod NUM_PORTS, go IDLE.
  - No timeout applies in this state.
- FLUSH:
  - s_payload_ready[g]=1; port g's bytes are discarded.
  - Accepted last: clear grant, rr_ptr=(g+1) mod NUM_PORTS, go IDLE.
- Boundary cases:
  - A re-asserted s_req[g] is arbitrated only from IDLE, so back-to-back frames from one port alternate fairly with other pending ports.
  - s_req deassertion after grant is ignored.
  - s_length=0: one-byte frame; the flow is unchanged.
- Reset mid-frame: everything returns to reset values next edge; no cancel is issued (the transmitter shares rst).
- Latency: s_req → m_start 1 cycle; m_tx_last handshake → next m_start 2 cycles.

Decomposition:
- Package etherneco_pkg holds:
  - the state enum;
  - t_length (16 bits);
  - t_type and t_node (8 bits);
  - the preamble/SFD constants shared with the transmitter.
- One natural sub-module, etherneco_rr_select: combinational round-robin priority select.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, index, any.

Test Plan:
- Single port 0 req, length=3, type=0x12, node=0x05, 4 payload bytes → m_start 1 cycle after req; m_param_*=3/0x12/0x05; 4 bytes routed; s_done[0] one cycle on the tx last handshake.
- Ports 0 and 1 both requesting continuously, each frame 1 byte → grants alternate 0,1,0,1; no port is granted twice in a row.
- Port 1 stalls payload valid for 8 cycles, param_timeout=5 → m_cancel and s_abort[1] pulse on the 5th stall cycle; FLUSH accepts the remaining 3 bytes through last; state returns to IDLE; no s_done.
- param_timeout=0 with a 100-cycle stall → no cancel; frame completes normally after the stall.
- m_payload_ready held low for 20 cycles while valid → no timeout (stall not attributed to source? counter counts non-handshake cycles—set param_timeout=30); payload resumes and completes.
- rst asserted during SEND → all outputs 0 next cycle; a new req is then served from port 0 with rr_ptr=0.
